reset_sequencer: RTL and testbench

Multi-channel successor to the single-output board resetter: takes the chip-wide synchronous reset, an asynchronous external reset pin and an optional in-domain soft reset request, and releases a vector of active-low reset outputs one channel at a time. Each release is spaced by a fixed counted delay. Sits at the top level next to the clock generator and feeds ordered resets to clocking, memory controller, CPU core and peripherals. Any reset source at any time re-asserts all outputs and restarts the whole sequence.

---
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 tb/tb_reset_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases CHANNELS active-low resets in ascending order,
// each spaced by 2^CNT_SIZE+1 cycles once every reset source is quiet.
// Define RESET_SEQ_SOFT_EN to let soft_rst_req restart the sequence; without
// it the port is present but has no effect.
module reset_sequencer #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned CNT_SIZE    = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ext_rst_n,
    input  logic                soft_rst_req,
    output logic [CHANNELS-1:0] rst_out_n,
    output logic                rst_done,
    output logic                busy
);

    localparam int unsigned ChW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ChW-1:0] LastCh = ChW'(CHANNELS - 1);
    localparam logic [ChW-1:0] ChOne = ChW'(1);
    localparam logic [CNT_SIZE:0] CntOne = (CNT_SIZE + 1)'(1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_SIZE:0]     cnt_q, cnt_d;
    logic [ChW-1:0]        ch_q, ch_d;
    logic [CHANNELS-1:0]   out_q, out_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  ext_s_n;
    logic                  req;
    logic                  term;

    // Synchronize the external pin; a cleared chain reads as reset asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n};
        end
    end

    assign ext_s_n = sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQ_SOFT_EN
    assign req = !ext_s_n | soft_rst_req;
`else
    logic unused_soft_rst_req;
    assign unused_soft_rst_req = soft_rst_req;
    assign req = !ext_s_n;
`endif

    assign term = cnt_q[CNT_SIZE];

    // State, counter, channel index and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StAssert;
            cnt_q   <= '0;
            ch_q    <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: any request wins, otherwise advance on the terminal count.
    always_comb begin
        state_d = state_q;
        if (req) begin
            state_d = StAssert;
        end else begin
            case (state_q)
                StAssert: begin
                    if (term) begin
                        state_d = (CHANNELS == 1) ? StRun : StRelease;
                    end
                end
                StRelease: begin
                    if (term && (ch_q == LastCh)) begin
                        state_d = StRun;
                    end
                end
                StRun:   state_d = StRun;
                default: state_d = StAssert;
            endcase
        end
    end

    // Next outputs and datapath: ASSERT and RELEASE share the release step
    // because ch is still 0 while asserting.
    always_comb begin
        cnt_d  = cnt_q;
        ch_d   = ch_q;
        out_d  = out_q;
        done_d = done_q;
        if (req) begin
            cnt_d  = '0;
            ch_d   = '0;
            out_d  = '0;
            done_d = 1'b0;
        end else begin
            case (state_q)
                StAssert, StRelease: begin
                    if (term) begin
                        cnt_d = '0;
                        ch_d  = ch_q + ChOne;
                        for (int i = 0; i < int'(CHANNELS); i++) begin
                            if (i == int'(ch_q)) begin
                                out_d[i] = 1'b1;
                            end
                        end
                        if (ch_q == LastCh) begin
                            done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    cnt_d = cnt_q;
                end
            endcase
        end
        busy_d = !done_d;
    end

    assign rst_out_n = out_q;
    assign rst_done  = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int CH   = 4;
    localparam int CS   = 4;
    localparam int SS   = 2;
    localparam int STEP = (1 << CS) + 1;
    localparam int MAXE = 8192;

`ifdef RESET_SEQ_SOFT_EN
    localparam bit SoftEn = 1'b1;
`else
    localparam bit SoftEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, ext_rst_n, soft_rst_req;
    logic [CH-1:0] rst_out_n;
    logic          rst_done, busy;

    logic          rst2 = 1'b1, ext2 = 1'b1, soft2 = 1'b0;
    logic [0:0]    out2;
    logic          done2, busy2;

    always #5 clk = ~clk;

    reset_sequencer #(.CHANNELS(CH), .CNT_SIZE(CS), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .soft_rst_req(soft_rst_req),
        .rst_out_n(rst_out_n), .rst_done(rst_done), .busy(busy)
    );

    reset_sequencer #(.CHANNELS(1), .CNT_SIZE(2), .SYNC_STAGES(3)) dut2 (
        .clk(clk), .rst(rst2), .ext_rst_n(ext2), .soft_rst_req(soft2),
        .rst_out_n(out2), .rst_done(done2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int last_req = 0;
    bit eff [MAXE];

    // Reference: channels released = (edges since last request)/STEP, capped.
    // eff[n] is the pin as seen at edge n, with reset treated as a low pin.
    function automatic int rel_exp();
        int r;
        r = (edge_n - last_req) / STEP;
        if (r > CH) r = CH;
        return r;
    endfunction

    function automatic logic [CH-1:0] out_exp();
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < rel_exp(); i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        bit req;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            eff[edge_n] = 1'b0;
            for (int i = 1; i < SS; i++) if (edge_n - i >= 0) eff[edge_n - i] = 1'b0;
            last_req = edge_n;
        end else begin
            eff[edge_n] = ext_rst_n;
            req = (edge_n - SS < 0) ? 1'b1 : !eff[edge_n - SS];
            if (SoftEn && soft_rst_req) req = 1'b1;
            if (req) last_req = edge_n;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ext_rst_n = 1'b1; soft_rst_req = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (rst_out_n !== '0) begin
                errors++; $display("FAIL reset rst_out_n got %b want 0000", rst_out_n);
            end
            checks++;
            if (rst_done !== 1'b0) begin
                errors++; $display("FAIL reset rst_done got %b want 0", rst_done);
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++; $display("FAIL reset busy got %b want 1", busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        int e0;
        e0 = edge_n;
        for (int k = 1; k <= 75; k++) begin
            step();
            checks++;
            if (rst_out_n !== out_exp() || rst_done !== (rel_exp() == CH)
                || busy !== (rel_exp() != CH)) begin
                errors++;
                $display("FAIL powerup E%0d out/done/busy got %b/%b/%b want %b/%b/%b", k,
                         rst_out_n, rst_done, busy, out_exp(), rel_exp() == CH, rel_exp() != CH);
            end
            if (edge_n - e0 == 19) begin
                checks++;
                if (rst_out_n !== 4'b0001) begin
                    errors++; $display("FAIL powerup_E19 got %b want 0001", rst_out_n);
                end
            end
            if (edge_n - e0 == 70) begin
                checks++;
                if (rst_out_n !== 4'b1111 || rst_done !== 1'b1) begin
                    errors++;
                    $display("FAIL powerup_E70 got %b/%b want 1111/1", rst_out_n, rst_done);
                end
            end
        end
    endtask

    task automatic test_soft_run();
        logic [CH-1:0] want_k;
        int ek;
        want_k = SoftEn ? 4'b0000 : 4'b1111;
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        ek = edge_n;
        checks++;
        if (rst_out_n !== want_k) begin
            errors++; $display("FAIL soft_at_Ek got %b want %b", rst_out_n, want_k);
        end
        for (int k = 1; k <= 75; k++) begin
            step();
            checks++;
            if (rst_out_n !== out_exp() || rst_done !== (rel_exp() == CH)) begin
                errors++;
                $display("FAIL soft Ek+%0d got %b/%b want %b/%b", edge_n - ek, rst_out_n,
                         rst_done, out_exp(), rel_exp() == CH);
            end
        end
    endtask

    task automatic test_ext_release();
        int n;
        int a;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (rel_exp() != 2 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n >= 200 || rst_out_n !== 4'b0011) begin
            errors++; $display("FAIL ext_wait_ch1 got %b want 0011", rst_out_n);
        end
        ext_rst_n = 1'b0;
        a = edge_n + 1;
        for (int k = 0; k < 100; k++) begin
            if (k == 5) ext_rst_n = 1'b1;
            step();
            if (edge_n == a + 1) begin
                checks++;
                if (rst_out_n !== 4'b0011) begin
                    errors++; $display("FAIL ext_a+1 got %b want 0011", rst_out_n);
                end
            end
            if (edge_n == a + 2) begin
                checks++;
                if (rst_out_n !== 4'b0000) begin
                    errors++; $display("FAIL ext_a+2 got %b want 0000", rst_out_n);
                end
            end
            checks++;
            if (rst_out_n !== out_exp()) begin
                errors++;
                $display("FAIL ext edge %0d got %b want %b", edge_n, rst_out_n, out_exp());
            end
        end
    endtask

    task automatic test_repeat_req();
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < 10; k++) begin
                soft_rst_req = (k == 0);
                step();
                checks++;
                if (rst_out_n !== out_exp()) begin
                    errors++;
                    $display("FAIL repeat p%0d k%0d got %b want %b", p, k, rst_out_n, out_exp());
                end
            end
        end
        soft_rst_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if (rst_out_n !== out_exp()) begin
                errors++;
                $display("FAIL repeat_tail k%0d got %b want %b", k, rst_out_n, out_exp());
            end
        end
    endtask

    task automatic test_random();
        int low_left;
        low_left = 0;
        for (int k = 0; k < 2000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            soft_rst_req = ($urandom_range(0, 59) == 0);
            if (low_left > 0) begin
                low_left--;
                ext_rst_n = 1'b0;
            end else if ($urandom_range(0, 119) == 0) begin
                low_left = $urandom_range(0, 5);
                ext_rst_n = 1'b0;
            end else begin
                ext_rst_n = 1'b1;
            end
            step();
            checks++;
            if (rst_out_n !== out_exp() || rst_done !== (rel_exp() == CH)
                || busy !== (rel_exp() != CH)) begin
                errors++;
                $display("FAIL random edge %0d got %b/%b/%b want %b/%b/%b", edge_n, rst_out_n,
                         rst_done, busy, out_exp(), rel_exp() == CH, rel_exp() != CH);
            end
        end
        rst = 1'b0; soft_rst_req = 1'b0; ext_rst_n = 1'b1;
    endtask

    // CHANNELS=1, CNT_SIZE=2, SYNC_STAGES=3: release at E(3+4+1).
    task automatic test_sweep();
        bit want;
        rst2 = 1'b1;
        repeat (3) step();
        checks++;
        if (out2 !== 1'b0 || done2 !== 1'b0 || busy2 !== 1'b1) begin
            errors++; $display("FAIL sweep_reset got %b/%b/%b want 0/0/1", out2, done2, busy2);
        end
        rst2 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            want = (k >= 8);
            checks++;
            if (out2 !== want || done2 !== want || busy2 !== !want) begin
                errors++;
                $display("FAIL sweep E%0d got %b/%b/%b want %b/%b/%b", k, out2, done2, busy2,
                         want, want, !want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_soft_run();
        test_ext_release();
        test_repeat_req();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
